// File: rtl/spi_slave_drive_if.sv
// spi_slave_drive_if: SPI pins plus the parallel tx/rx side of the responder.
// slave modport faces the responder, master modport faces its driver.
interface spi_slave_drive_if #(
  parameter int DATA_WITH      = 29,
  parameter int READ_DATA_WITH = 29
) ();
  logic                      sync;
  logic                      sclk;
  logic                      sdi;
  logic                      sdo;
  logic                      sdo_oe;
  logic [READ_DATA_WITH-1:0] tx_data;
  logic                      tx_load;
  logic                      tx_pending;
  logic [DATA_WITH-1:0]      rx_data;
  logic                      rx_vld;
  logic                      frame_err;

  modport slave (
    input  sync, sclk, sdi, tx_data, tx_load,
    output sdo, sdo_oe, tx_pending, rx_data, rx_vld, frame_err
  );

  modport master (
    output sync, sclk, sdi, tx_data, tx_load,
    input  sdo, sdo_oe, tx_pending, rx_data, rx_vld, frame_err
  );
endinterface

// File: rtl/spi_slave_drive.sv
// spi_slave_drive: oversampled SPI responder, deserialises sdi, serialises sdo.
// Ports: clk, rst_n (async low), bus (slave modport: SPI pins, tx load, rx out).
module spi_slave_drive #(
  parameter int   DATA_WITH      = 29,
  parameter int   READ_DATA_WITH = 29,
  parameter logic CPOL           = 1'b0,
  parameter logic CPHL           = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  spi_slave_drive_if.slave bus
);

  localparam int CW = $clog2(DATA_WITH + 2);
  localparam int TW = $clog2(READ_DATA_WITH + 1);
  localparam logic [CW-1:0] CNT_OK  = CW'(DATA_WITH);
  localparam logic [CW-1:0] CNT_MAX = CW'(DATA_WITH + 1);
  localparam logic [TW-1:0] TX_ALL  = TW'(READ_DATA_WITH);
  localparam logic [TW-1:0] TX_ONE  = TW'(READ_DATA_WITH - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ACTIVE    = 2'd1;
  localparam logic [1:0] WAIT_SYNC = 2'd2;

  logic [2:0] sync_q;
  logic [2:0] sclk_q;
  logic [1:0] sdi_q;

  // sync flops clear low so a master holding sync low through reset
  // keeps the block in WAIT_SYNC instead of faking a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      sclk_q <= {3{CPOL}};
      sdi_q  <= '0;
    end else begin
      sync_q <= {sync_q[1:0], bus.sync};
      sclk_q <= {sclk_q[1:0], bus.sclk};
      sdi_q  <= {sdi_q[0], bus.sdi};
    end
  end

  logic sync_rise, sync_fall;
  logic sclk_rise, sclk_fall;
  logic lead, trail;
  logic sample_edge, shift_edge;

  assign sync_rise   = sync_q[1] & ~sync_q[2];
  assign sync_fall   = ~sync_q[1] & sync_q[2];
  assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall   = ~sclk_q[1] & sclk_q[2];
  assign lead        = CPOL ? sclk_fall : sclk_rise;
  assign trail       = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHL ? trail : lead;
  assign shift_edge  = CPHL ? lead : trail;

  logic [1:0]                state;
  logic [CW-1:0]             bit_cnt;
  logic [DATA_WITH-1:0]      rx_sr;
  logic [DATA_WITH-1:0]      rx_data_r;
  logic [READ_DATA_WITH-1:0] shadow;
  logic [READ_DATA_WITH-1:0] pend;
  logic [READ_DATA_WITH-1:0] tx_sr;
  logic [READ_DATA_WITH-1:0] next_shadow;
  logic [TW-1:0]             tx_left;
  logic                      pend_vld;
  logic                      sdo_r;
  logic                      sdo_oe_r;
  logic                      rx_vld_r;
  logic                      frame_err_r;

  assign next_shadow = pend_vld ? pend : shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_SYNC;
      bit_cnt     <= '0;
      rx_sr       <= '0;
      rx_data_r   <= '0;
      shadow      <= '0;
      pend        <= '0;
      tx_sr       <= '0;
      tx_left     <= '0;
      pend_vld    <= 1'b0;
      sdo_r       <= 1'b0;
      sdo_oe_r    <= 1'b0;
      rx_vld_r    <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      rx_vld_r    <= 1'b0;
      frame_err_r <= 1'b0;
      if (bus.tx_load) begin
        pend     <= bus.tx_data;
        pend_vld <= 1'b1;
      end
      case (state)
        WAIT_SYNC: begin
          if (sync_q[1]) state <= IDLE;
        end
        IDLE: begin
          if (sync_fall) begin
            state    <= ACTIVE;
            bit_cnt  <= '0;
            rx_sr    <= '0;
            shadow   <= next_shadow;
            sdo_oe_r <= 1'b1;
            // a load landing on the start cycle stays pending
            if (!bus.tx_load) pend_vld <= 1'b0;
            if (CPHL) begin
              tx_sr   <= next_shadow;
              tx_left <= TX_ALL;
            end else begin
              sdo_r   <= next_shadow[READ_DATA_WITH-1];
              tx_sr   <= next_shadow << 1;
              tx_left <= TX_ONE;
            end
          end
        end
        ACTIVE: begin
          if (sync_rise) begin
            state    <= IDLE;
            sdo_r    <= 1'b0;
            sdo_oe_r <= 1'b0;
            if (bit_cnt == CNT_OK) begin
              rx_data_r <= rx_sr;
              rx_vld_r  <= 1'b1;
            end else begin
              frame_err_r <= 1'b1;
            end
          end else begin
            if (sample_edge) begin
              rx_sr <= {rx_sr[DATA_WITH-2:0], sdi_q[1]};
              if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
            end
            if (shift_edge) begin
              if (tx_left != '0) begin
                sdo_r   <= tx_sr[READ_DATA_WITH-1];
                tx_sr   <= tx_sr << 1;
                tx_left <= tx_left - 1'b1;
              end else begin
                sdo_r <= 1'b0;
              end
            end
          end
        end
        default: state <= WAIT_SYNC;
      endcase
    end
  end

  assign bus.sdo        = sdo_r;
  assign bus.sdo_oe     = sdo_oe_r;
  assign bus.tx_pending = pend_vld;
  assign bus.rx_data    = rx_data_r;
  assign bus.rx_vld     = rx_vld_r;
  assign bus.frame_err  = frame_err_r;

endmodule
